// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared constants and FSM state type for the ROB slot allocator.
package rob_alloc_ctrl_pkg;

  localparam int unsigned ROB_SLOTS      = 16;
  localparam int unsigned ROB_IDX_BITS   = 4;
  localparam int unsigned ARCH_BITS      = 32;
  localparam int unsigned FLUSH_CNT_BITS = 4;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rob_alloc_ctrl_ptr_ctr.sv
// Wrap-around ROB pointer with synchronous clear; used for both head and tail.
module rob_ptr_ctr #(
  parameter int unsigned W = rob_alloc_ctrl_pkg::ROB_IDX_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// In-order ROB slot allocator: grants tail indices, tracks occupancy, recovers after flush.
// Optional ROB_ALLOC_STATS_EN adds stall_cnt and peak_occ statistics outputs.
module rob_alloc_ctrl #(
  parameter int unsigned ROB_SLOTS    = rob_alloc_ctrl_pkg::ROB_SLOTS,
  parameter int unsigned ROB_IDX_BITS = rob_alloc_ctrl_pkg::ROB_IDX_BITS,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  output logic [ROB_IDX_BITS-1:0] alloc_idx,
  input  logic                    commit,
  output logic [ROB_IDX_BITS:0]   occupancy,
  output logic                    rob_empty,
  output logic                    rob_full,
  output logic                    underflow
`ifdef ROB_ALLOC_STATS_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [ROB_IDX_BITS:0]   peak_occ
`endif
);

  import rob_alloc_ctrl_pkg::*;

  localparam logic [ROB_IDX_BITS:0]   OCC_FULL = (ROB_IDX_BITS+1)'(ROB_SLOTS);
  localparam logic [ROB_IDX_BITS:0]   OCC_ONE  = (ROB_IDX_BITS+1)'(1);
  localparam logic [FLUSH_CNT_BITS-1:0] FLUSH_LOAD = FLUSH_CNT_BITS'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_BITS-1:0] CNT_ONE    = FLUSH_CNT_BITS'(1);

  alloc_state_e                state, state_next;
  logic [FLUSH_CNT_BITS-1:0]   flush_cnt, cnt_next;
  logic [ROB_IDX_BITS:0]       occ_next;
  logic [ROB_IDX_BITS-1:0]     head;
  logic                        fire, commit_ok;

  assign fire      = alloc_valid && alloc_ready;
  assign commit_ok = commit && (occupancy != '0);
  assign rob_empty = (occupancy == '0);
  assign rob_full  = (occupancy == OCC_FULL);

  rob_ptr_ctr #(.W(ROB_IDX_BITS)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (fire),
    .ptr (alloc_idx)
  );

  rob_ptr_ctr #(.W(ROB_IDX_BITS)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (commit_ok),
    .ptr (head)
  );

  always_comb begin
    occ_next   = occupancy;
    state_next = state;
    cnt_next   = flush_cnt;
    if (flush) begin
      occ_next   = '0;
      state_next = ST_RECOVER;
      cnt_next   = FLUSH_LOAD;
    end else begin
      if (fire && !commit_ok) begin
        occ_next = occupancy + OCC_ONE;
      end else if (!fire && commit_ok) begin
        occ_next = occupancy - OCC_ONE;
      end
      if (state == ST_RECOVER) begin
        if (flush_cnt <= CNT_ONE) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = flush_cnt - CNT_ONE;
        end
      end
    end
  end

  // alloc_ready is precomputed from next-state values so it is a pure register output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      flush_cnt   <= '0;
      occupancy   <= '0;
      alloc_ready <= 1'b1;
      underflow   <= 1'b0;
    end else begin
      state       <= state_next;
      flush_cnt   <= cnt_next;
      occupancy   <= occ_next;
      alloc_ready <= (state_next == ST_RUN) && (occ_next != OCC_FULL);
      if (commit && (occupancy == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef ROB_ALLOC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      peak_occ  <= '0;
    end else begin
      if (alloc_valid && !alloc_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (occ_next > peak_occ) begin
        peak_occ <= occ_next;
      end
    end
  end
`endif

  // Pointer distance must always agree with the occupancy count (mod ROB_SLOTS).
  ptr_consistent: assert property (@(posedge clk) disable iff (rst)
    (alloc_idx - head) == occupancy[ROB_IDX_BITS-1:0]);

endmodule
